alu8_issue_wb: RTL and testbench



---
 rtl/alu8_pkg.sv | 29 ++
 rtl/alu8_regfile.sv | 39 +++
 rtl/alu8_issue_wb.sv | 116 +++++++++++
 tb/tb_alu8_issue_wb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu8_pkg.sv
// Shared definitions for the ALU issue/writeback slice: default widths,
// ALU function-select codes and the legal-code predicate.
package alu8_pkg;

    localparam int unsigned ALU8_DATA_W = 8;
    localparam int unsigned ALU8_AREG_W = 3;
    localparam int unsigned FS_W        = 5;

    localparam logic [FS_W-1:0] FS_ADD    = 5'h00;
    localparam logic [FS_W-1:0] FS_SUB    = 5'h01;
    localparam logic [FS_W-1:0] FS_AND    = 5'h08;
    localparam logic [FS_W-1:0] FS_OR     = 5'h09;
    localparam logic [FS_W-1:0] FS_XOR    = 5'h0A;
    localparam logic [FS_W-1:0] FS_CMPEQ  = 5'h0B;
    localparam logic [FS_W-1:0] FS_PASS_S = 5'h10;

    localparam logic [7:0] BAD_CNT_MAX = 8'hFF;

    function automatic logic fs_is_legal(input logic [FS_W-1:0] fs);
        logic legal;
        legal = 1'b0;
        unique case (fs)
            FS_ADD, FS_SUB, FS_AND, FS_OR, FS_XOR, FS_CMPEQ, FS_PASS_S: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu8_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// R0 reads as zero and is never written.
module alu8_regfile
    import alu8_pkg::*;
#(
    parameter int unsigned DATA_W = ALU8_DATA_W,
    parameter int unsigned AREG_W = ALU8_AREG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AREG_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AREG_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [AREG_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int unsigned NREG = 2 ** AREG_W;

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
        rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];
    end

endmodule

// File: rtl/alu8_issue_wb.sv
// Operand-issue and writeback stage around the 8-bit combinational ALU.
// ALU8_BYPASS_EN selects the E->issue result bypass; otherwise a one-cycle interlock.
module alu8_issue_wb
    import alu8_pkg::*;
#(
    parameter int unsigned DATA_W = ALU8_DATA_W,
    parameter int unsigned AREG_W = ALU8_AREG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_fs,
    input  logic [AREG_W-1:0] in_rs,
    input  logic [AREG_W-1:0] in_rt,
    input  logic [AREG_W-1:0] in_rd,
    input  logic              in_imm_en,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              hold,
    output logic [DATA_W-1:0] alu_s,
    output logic [DATA_W-1:0] alu_t,
    output logic [4:0]        alu_fs,
    input  logic [DATA_W-1:0] alu_vy_hi,
    input  logic [DATA_W-1:0] alu_vy_lo,
    output logic              wb_valid,
    output logic [AREG_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] hi_q,
    output logic [7:0]        bad_fs_cnt
);

    logic              e_valid;
    logic [AREG_W-1:0] e_rd;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] op_s;
    logic [DATA_W-1:0] op_t;
    logic              accept;
    logic              wb_en;

    assign wb_en = e_valid & ~hold;

    alu8_regfile #(
        .DATA_W (DATA_W),
        .AREG_W (AREG_W)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .ra_addr (in_rs),
        .ra_data (rf_a),
        .rb_addr (in_rt),
        .rb_data (rf_b),
        .we      (wb_en),
        .wa      (e_rd),
        .wd      (alu_vy_lo)
    );

`ifdef ALU8_BYPASS_EN
    // The result being written this edge is forwarded so a dependent issue never sees stale R[x].
    always_comb begin
        op_s = rf_a;
        op_t = rf_b;
        if (e_valid && (in_rs != '0) && (e_rd == in_rs)) begin
            op_s = alu_vy_lo;
        end
        if (e_valid && (in_rt != '0) && (e_rd == in_rt)) begin
            op_t = alu_vy_lo;
        end
        in_ready = ~hold;
    end
`else
    always_comb begin
        op_s = rf_a;
        op_t = rf_b;
        in_ready = ~hold & ~(e_valid & (e_rd != '0) &
                             ((in_rs == e_rd) | (~in_imm_en & (in_rt == e_rd))));
    end
`endif

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e_valid    <= 1'b0;
            e_rd       <= '0;
            alu_s      <= '0;
            alu_t      <= '0;
            alu_fs     <= FS_PASS_S;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            hi_q       <= '0;
            bad_fs_cnt <= '0;
        end else if (hold) begin
            wb_valid <= 1'b0;
        end else begin
            e_valid  <= accept;
            wb_valid <= e_valid;
            if (accept) begin
                alu_s  <= op_s;
                alu_t  <= in_imm_en ? in_imm : op_t;
                alu_fs <= in_fs;
                e_rd   <= in_rd;
            end
            if (e_valid) begin
                wb_rd   <= e_rd;
                wb_data <= alu_vy_lo;
                hi_q    <= alu_vy_hi;
                if (!fs_is_legal(alu_fs) && (bad_fs_cnt != BAD_CNT_MAX)) begin
                    bad_fs_cnt <= bad_fs_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu8_issue_wb.sv
// Randomised self-checking bench for alu8_issue_wb with an in-order
// architectural reference model and a behavioural ALU driving alu_vy_*.
module tb_alu8_issue_wb;

`ifdef ALU8_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_fs;
    logic [2:0] in_rs;
    logic [2:0] in_rt;
    logic [2:0] in_rd;
    logic       in_imm_en;
    logic [7:0] in_imm;
    logic       hold;
    logic [7:0] alu_s;
    logic [7:0] alu_t;
    logic [4:0] alu_fs;
    logic [7:0] alu_vy_hi;
    logic [7:0] alu_vy_lo;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic [7:0] hi_q;
    logic [7:0] bad_fs_cnt;

    alu8_issue_wb #(
        .DATA_W (8),
        .AREG_W (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fs      (in_fs),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm_en  (in_imm_en),
        .in_imm     (in_imm),
        .hold       (hold),
        .alu_s      (alu_s),
        .alu_t      (alu_t),
        .alu_fs     (alu_fs),
        .alu_vy_hi  (alu_vy_hi),
        .alu_vy_lo  (alu_vy_lo),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .hi_q       (hi_q),
        .bad_fs_cnt (bad_fs_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit legal_fs(input logic [4:0] fs);
        return fs inside {5'h00, 5'h01, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h10};
    endfunction

    // Behavioural ALU: {hi, lo}; hi carries the ADD carry / SUB borrow.
    function automatic logic [15:0] alu_ref(input logic [4:0] fs, input logic [7:0] s, input logic [7:0] t);
        int unsigned sum;
        case (fs)
            5'h00: begin sum = int'(s) + int'(t); return {7'd0, sum[8], sum[7:0]}; end
            5'h01: return {7'd0, (s < t), 8'(s - t)};
            5'h08: return {8'h00, s & t};
            5'h09: return {8'h00, s | t};
            5'h0A: return {8'h00, s ^ t};
            5'h0B: return {8'h00, (s == t) ? 8'hFF : 8'h00};
            5'h10: return {8'h00, s};
            default: return 16'h0FF0;
        endcase
    endfunction

    always_comb {alu_vy_hi, alu_vy_lo} = alu_ref(alu_fs, alu_s, alu_t);

    // Reference model state
    logic [7:0] m_r [8];
    bit         m_pend;
    logic [2:0] m_prd;
    logic [7:0] m_plo, m_phi;
    logic [4:0] m_pfs;
    logic [7:0] m_s, m_t;
    logic [4:0] m_fs;
    bit         m_wbv;
    logic [2:0] m_wbrd;
    logic [7:0] m_wbd, m_hi, m_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    int         stall_cnt;
    logic [7:0] wb_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        m_pend = 0; m_prd = 0; m_plo = 0; m_phi = 0; m_pfs = 0;
        m_s = 0; m_t = 0; m_fs = 5'h10;
        m_wbv = 0; m_wbrd = 0; m_wbd = 0; m_hi = 0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        check("wb_valid", wb_valid, m_wbv);
        check("wb_rd", wb_rd, m_wbrd);
        check("wb_data", wb_data, m_wbd);
        check("hi_q", hi_q, m_hi);
        check("bad_fs_cnt", bad_fs_cnt, m_cnt);
        check("alu_s", alu_s, m_s);
        check("alu_t", alu_t, m_t);
        check("alu_fs", alu_fs, m_fs);
    endtask

    task automatic step(input bit v, input logic [4:0] fs, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input bit ie, input logic [7:0] imm, input bit h,
                        output bit acc);
        bit exp_rdy;
        logic [7:0] s, t;
        logic [15:0] r;
        @(negedge clk);
        in_valid = v; in_fs = fs; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm_en = ie; in_imm = imm; hold = h;
        #1;
        exp_rdy = !h && (BYP || !(m_pend && m_prd != 0 && (rs == m_prd || (!ie && rt == m_prd))));
        check("in_ready", in_ready, exp_rdy);
        if (v && !h && !in_ready) stall_cnt++;
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (h) begin
            m_wbv = 0;
        end else begin
            m_wbv = m_pend;
            if (m_pend) begin
                m_wbrd = m_prd; m_wbd = m_plo; m_hi = m_phi;
                if (!legal_fs(m_pfs) && m_cnt != 8'hFF) m_cnt++;
            end
            m_pend = acc;
            if (acc) begin
                s = m_r[rs];
                t = ie ? imm : m_r[rt];
                r = alu_ref(fs, s, t);
                m_s = s; m_t = t; m_fs = fs;
                m_prd = rd; m_plo = r[7:0]; m_phi = r[15:8]; m_pfs = fs;
                if (rd != 0) m_r[rd] = r[7:0];
            end
        end
        check_outputs();
        if (wb_valid) wb_log.push_back(wb_data);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 5'h00, 0, 0, 0, 0, 8'h00, 0, a);
    endtask

    task automatic issue(input logic [4:0] fs, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd, input bit ie, input logic [7:0] imm);
        bit a;
        a = 0;
        for (int i = 0; i < 8 && !a; i++) step(1, fs, rs, rt, rd, ie, imm, 0, a);
        if (!a) check("issue_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0; in_valid = 0; hold = 0;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        bit a;
        logic [4:0] fs;
        reset_n = 0; in_valid = 0; in_fs = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_imm_en = 0; in_imm = 0; hold = 0;
        model_reset();
        do_reset();

        // ADD imm 5 -> R1
        issue(5'h00, 0, 0, 1, 1, 8'h05);
        idle(1);
        check("t1_wb_valid", wb_valid, 1);
        check("t1_wb_rd", wb_rd, 1);
        check("t1_wb_data", wb_data, 8'h05);

        // Dependent back-to-back pair
        stall_cnt = 0;
        issue(5'h01, 1, 0, 2, 1, 8'h03);
        issue(5'h00, 2, 1, 3, 0, 8'h00);
        idle(2);
        check("t2_stall_cycles", stall_cnt, BYP ? 0 : 1);
        check("t2_sub", wb_log[wb_log.size()-2], 8'h02);
        check("t2_add", wb_log[wb_log.size()-1], 8'h07);

        // Hold with an instruction in E
        issue(5'h00, 1, 0, 2, 1, 8'h10);
        for (int i = 0; i < 3; i++) begin
            step(1, 5'h00, 0, 0, 4, 1, 8'h77, 1, a);
            check("hold_no_wb", wb_valid, 0);
        end
        idle(1);
        check("hold_release_wb", wb_valid, 1);
        check("hold_release_data", wb_data, 8'h15);

        // CMPEQ and an illegal code
        issue(5'h0B, 1, 1, 4, 0, 8'h00);
        idle(1);
        check("cmpeq", wb_data, 8'hFF);
        issue(5'h1F, 1, 2, 5, 0, 8'h00);
        idle(1);
        check("illegal_data", wb_data, 8'hF0);
        check("illegal_cnt", bad_fs_cnt, 8'h01);

        // Write to R0, then read it back
        issue(5'h00, 0, 0, 0, 1, 8'hAA);
        idle(1);
        check("r0_wb_valid", wb_valid, 1);
        check("r0_wb_rd", wb_rd, 0);
        check("r0_wb_data", wb_data, 8'hAA);
        issue(5'h10, 0, 0, 6, 0, 8'h00);
        idle(1);
        check("r0_read", wb_data, 8'h00);

        // Saturate the illegal counter
        for (int i = 0; i < 300; i++) begin
            do fs = 5'($urandom); while (legal_fs(fs));
            issue(fs, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 8'($urandom));
        end
        idle(2);
        check("cnt_saturated", bad_fs_cnt, 8'hFF);

        // Reset with an instruction in flight
        issue(5'h00, 0, 0, 1, 1, 8'h5A);
        do_reset();
        check("mid_reset_wb", wb_valid, 0);
        check("mid_reset_fs", alu_fs, 5'h10);
        issue(5'h10, 1, 0, 4, 0, 8'h00);
        idle(1);
        check("mid_reset_r1", wb_data, 8'h00);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) fs = 5'($urandom);
            else case ($urandom_range(6))
                0: fs = 5'h00; 1: fs = 5'h01; 2: fs = 5'h08; 3: fs = 5'h09;
                4: fs = 5'h0A; 5: fs = 5'h0B; default: fs = 5'h10;
            endcase
            step($urandom_range(3) != 0, fs, 3'($urandom), 3'($urandom), 3'($urandom),
                 1'($urandom), 8'($urandom), $urandom_range(7) == 0, a);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
